core_bus_arb: RTL

CORE_BUS_ARB -- requirements
Module: core_bus_arb

---
 rtl/core_bus_arb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/core_bus_arb.sv
// Two-requester (IFU/LSU) round-robin arbiter onto a shared in-order bus.
// An owner FIFO remembers who issued each request so responses can be routed back.
module core_bus_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ifu_req_valid,
    output logic                       ifu_req_ready,
    input  logic [ADDR_W-1:0]          ifu_req_addr,
    input  logic                       lsu_req_valid,
    output logic                       lsu_req_ready,
    input  logic [ADDR_W-1:0]          lsu_req_addr,
    input  logic                       lsu_req_we,
    input  logic [DATA_W-1:0]          lsu_req_wdata,
    output logic                       bus_req_valid,
    output logic [ADDR_W-1:0]          bus_req_addr,
    output logic                       bus_req_we,
    output logic [DATA_W-1:0]          bus_req_wdata,
    input  logic                       bus_rsp_valid,
    input  logic [DATA_W-1:0]          bus_rsp_data,
    output logic                       ifu_rsp_valid,
    output logic [DATA_W-1:0]          ifu_rsp_data,
    output logic                       lsu_rsp_valid,
    output logic [DATA_W-1:0]          lsu_rsp_data,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       err_orphan
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    owner_e             last_grant;
    owner_e             winner;
    owner_e             head_owner;
    owner_e             owner_mem [MAX_OUT];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               accept;
    logic               pop;
    logic               orphan;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        winner = OWN_IFU;
        if (ifu_req_valid && lsu_req_valid)
            winner = (last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
        else if (lsu_req_valid)
            winner = OWN_LSU;
    end

    // Ready depends only on occupancy, never on a same-cycle response, to keep the path short.
    assign full          = (outstanding == MAX_CNT);
    assign accept        = (ifu_req_valid || lsu_req_valid) && !full && !rst;
    assign ifu_req_ready = accept && (winner == OWN_IFU);
    assign lsu_req_ready = accept && (winner == OWN_LSU);

    always_comb begin
        bus_req_valid = accept;
        bus_req_addr  = '0;
        bus_req_we    = 1'b0;
        bus_req_wdata = '0;
        if (accept) begin
            if (winner == OWN_LSU) begin
                bus_req_addr  = lsu_req_addr;
                bus_req_we    = lsu_req_we;
                bus_req_wdata = lsu_req_wdata;
            end else begin
                bus_req_addr  = ifu_req_addr;
            end
        end
    end

    assign pop        = bus_rsp_valid && (outstanding != '0);
    assign orphan     = bus_rsp_valid && (outstanding == '0);
    assign head_owner = owner_mem[rd_ptr];

    // NOTE: the owner storage has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (accept)
            owner_mem[wr_ptr] <= winner;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            last_grant    <= OWN_LSU;
            err_orphan    <= 1'b0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
        end else begin
            if (accept) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                last_grant <= winner;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            ifu_rsp_valid <= pop && (head_owner == OWN_IFU);
            lsu_rsp_valid <= pop && (head_owner == OWN_LSU);
            if (pop && head_owner == OWN_IFU)
                ifu_rsp_data <= bus_rsp_data;
            if (pop && head_owner == OWN_LSU)
                lsu_rsp_data <= bus_rsp_data;

            if (orphan)
                err_orphan <= 1'b1;
        end
    end

endmodule
